// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wjbot_riscv -- shared definitions for the memory arbiter slice.
//   arb_state_t          : arbiter FSM encoding (IDLE, GNT_C, GNT_D)
//   ARB_TIMEOUT_DEFAULT  : default number of granted cycles before abort
//   ARB_CNT_W            : wait-counter width, wide enough for TIMEOUT <= 255
// ---------------------------------------------------------------------------
package wjbot_riscv;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_C = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   localparam int ARB_TIMEOUT_DEFAULT = 16;
   localparam int ARB_CNT_W           = 8;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// ---------------------------------------------------------------------------
// wait_counter -- counts granted cycles that pass without a memory ack.
//   clk    : clock
//   reset  : synchronous, active-high
//   clear  : restart from zero (asserted on the granting edge)
//   enable : count this cycle (granted and no ack)
//   tc     : count has reached TIMEOUT-1, i.e. this is the last granted cycle
// ---------------------------------------------------------------------------
module wait_counter
   import wjbot_riscv::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
)
(
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [ARB_CNT_W-1:0] TC_VALUE = ARB_CNT_W'(TIMEOUT - 1);

   logic [ARB_CNT_W-1:0] count;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !tc) begin
         // Holds at the terminal value; the arbiter leaves the grant anyway.
         count <= count + 1'b1;
      end
   end

   assign tc = (count == TC_VALUE);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter -- two-port (core / debug-loader) arbiter in front of a single
// memory port, with round-robin fairness and a per-transaction timeout.
//   clk, reset                        : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata         : core request
//   c_done/c_err                      : core completion pulse / timeout flag
//   d_req/d_we/d_addr/d_wdata         : debug request
//   d_done/d_err                      : debug completion pulse / timeout flag
//   rdata                             : read data, valid with c_done/d_done
//   m_req/m_we/m_addr/m_wdata         : memory request (latched at grant)
//   m_ack/m_rdata                     : memory completion pulse and data
// ---------------------------------------------------------------------------
module mem_arbiter
   import wjbot_riscv::*;
#(
   parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_done,
   output logic        c_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ack,
   input  logic [31:0] m_rdata
);

   arb_state_t state;
   logic       favour_d;   // round-robin pointer: 1 = debug wins a tie
   logic       elig_c;
   logic       elig_d;
   logic       grant_c;
   logic       grant_d;
   logic       busy;
   logic       finish;
   logic       tc;

   // A requester is masked during its own done cycle so a held req is only
   // seen as a fresh request one cycle later.
   assign elig_c = c_req & ~c_done;
   assign elig_d = d_req & ~d_done;
   assign busy   = (state != IDLE);
   // An ack arriving on the timeout cycle still completes normally.
   assign finish = busy & (m_ack | tc);

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      grant_c = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         if (elig_c && (!elig_d || !favour_d)) begin
            grant_c = 1'b1;
         end else if (elig_d) begin
            grant_d = 1'b1;
         end
      end
   end

   wait_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_wait (
      .clk    (clk),
      .reset  (reset),
      .clear  (grant_c | grant_d),
      .enable (busy & ~m_ack),
      .tc     (tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the latched request and rdata are plain registers, not a
         // memory array, so they are cleared with the rest of the state.
         state    <= IDLE;
         favour_d <= 1'b0;
         m_req    <= 1'b0;
         m_we     <= 1'b0;
         m_addr   <= 32'h0;
         m_wdata  <= 32'h0;
         rdata    <= 32'h0;
         c_done   <= 1'b0;
         d_done   <= 1'b0;
         c_err    <= 1'b0;
         d_err    <= 1'b0;
      end else begin
         c_done <= 1'b0;
         d_done <= 1'b0;
         c_err  <= 1'b0;
         d_err  <= 1'b0;
         if (grant_c) begin
            state   <= GNT_C;
            m_req   <= 1'b1;
            m_we    <= c_we;
            m_addr  <= c_addr;
            m_wdata <= c_wdata;
         end else if (grant_d) begin
            state   <= GNT_D;
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
         end else if (finish) begin
            state    <= IDLE;
            m_req    <= 1'b0;
            // Point at whoever was not just served.
            favour_d <= (state == GNT_C);
            c_done   <= (state == GNT_C);
            d_done   <= (state == GNT_D);
            c_err    <= (state == GNT_C) & ~m_ack;
            d_err    <= (state == GNT_D) & ~m_ack;
            if (m_ack) begin
               rdata <= m_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
// A transaction-level reference model (owner, granted-cycle count, who was
// served last) predicts every output each cycle; directed steps then check
// the headline scenarios against fixed constants, followed by a random phase.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c_req = 1'b0, c_we = 1'b0;
   logic [31:0] c_addr = 32'h0, c_wdata = 32'h0;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
   logic        m_ack = 1'b0;
   logic [31:0] m_rdata = 32'h0;
   logic        c_done, c_err, d_done, d_err;
   logic        m_req, m_we;
   logic [31:0] rdata, m_addr, m_wdata;

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .reset   (reset),
      .c_req   (c_req),
      .c_we    (c_we),
      .c_addr  (c_addr),
      .c_wdata (c_wdata),
      .c_done  (c_done),
      .c_err   (c_err),
      .d_req   (d_req),
      .d_we    (d_we),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_done  (d_done),
      .d_err   (d_err),
      .rdata   (rdata),
      .m_req   (m_req),
      .m_we    (m_we),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_ack   (m_ack),
      .m_rdata (m_rdata)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: owner 0 = nobody, 1 = core, 2 = debug.
   int          owner = 0, gcyc = 0, next_first = 1;
   bit          e_mreq = 0, e_mwe = 0, e_cdone = 0, e_ddone = 0, e_cerr = 0, e_derr = 0;
   logic [31:0] e_maddr = 32'h0, e_mwdata = 32'h0, e_rdata = 32'h0;

   // Stimulus control.
   int          ack_lat = 0;         // granted-cycle index on which memory acks
   bit          rand_lat = 0, rand_mode = 0, hold_reqs = 0, idle_ack = 0;
   bit          drop_c = 0, drop_d = 0;
   logic [31:0] ack_data = 32'h0;

   // Statistics observed on the DUT outputs.
   int          n_cdone = 0, n_ddone = 0, n_cerr = 0, n_derr = 0, n_mreq = 0;
   int          n_overlap = 0, n_dboth = 0, done_n = 0;
   logic [31:0] done_seq = 32'h0;

   int          b_cdone, b_ddone, b_cerr, b_derr, b_mreq, b_dboth, b_done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance the model by one rising edge using the inputs sampled there.
   function automatic void model_edge();
      bit pc, pd;
      if (reset) begin
         owner = 0; gcyc = 0; next_first = 1;
         e_mreq = 0; e_mwe = 0; e_maddr = 32'h0; e_mwdata = 32'h0; e_rdata = 32'h0;
         e_cdone = 0; e_ddone = 0; e_cerr = 0; e_derr = 0;
         return;
      end
      pc = c_req && !e_cdone;
      pd = d_req && !e_ddone;
      e_cdone = 0; e_ddone = 0; e_cerr = 0; e_derr = 0;
      if (owner != 0) begin
         if (m_ack || gcyc == TIMEOUT - 1) begin
            if (owner == 1) begin e_cdone = 1; e_cerr = !m_ack; end
            else            begin e_ddone = 1; e_derr = !m_ack; end
            if (m_ack) e_rdata = m_rdata;
            next_first = (owner == 1) ? 2 : 1;
            owner  = 0;
            e_mreq = 0;
         end else begin
            gcyc++;
         end
      end else if (pc || pd) begin
         owner = (pc && pd) ? next_first : (pc ? 1 : 2);
         if (owner == 1) begin
            e_mwe = c_we; e_maddr = c_addr; e_mwdata = c_wdata;
            drop_c = !hold_reqs && (!rand_mode || $urandom_range(0, 3) != 0);
         end else begin
            e_mwe = d_we; e_maddr = d_addr; e_mwdata = d_wdata;
            drop_d = !hold_reqs && (!rand_mode || $urandom_range(0, 3) != 0);
         end
         e_mreq = 1;
         gcyc   = 0;
         if (rand_lat) ack_lat = $urandom_range(0, TIMEOUT + 3);
      end
   endfunction

   // One clock: drive memory response, step DUT and model, compare outputs.
   task automatic cycle();
      m_ack   = (owner != 0) ? (gcyc == ack_lat) : idle_ack;
      m_rdata = m_ack ? ack_data : $urandom();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("m_req",  m_req,  e_mreq);
      check("c_done", c_done, e_cdone);
      check("d_done", d_done, e_ddone);
      check("c_err",  c_err,  e_cerr);
      check("d_err",  d_err,  e_derr);
      check("rdata",  rdata,  e_rdata);
      if (e_mreq) begin
         check("m_we",    m_we,    e_mwe);
         check("m_addr",  m_addr,  e_maddr);
         check("m_wdata", m_wdata, e_mwdata);
      end
      if (c_done === 1'b1) begin n_cdone++; done_n++; done_seq = {done_seq[27:0], 4'hC}; end
      if (d_done === 1'b1) begin n_ddone++; done_n++; done_seq = {done_seq[27:0], 4'hD}; end
      if (c_err === 1'b1) n_cerr++;
      if (d_err === 1'b1) n_derr++;
      if (m_req === 1'b1) n_mreq++;
      if (c_done === 1'b1 && d_done === 1'b1) n_overlap++;
      if (d_done === 1'b1 && d_err === 1'b1) n_dboth++;
      if (drop_c) begin c_req = 1'b0; drop_c = 0; end
      if (drop_d) begin d_req = 1'b0; drop_d = 0; end
   endtask

   task automatic snap();
      b_cdone = n_cdone; b_ddone = n_ddone; b_cerr = n_cerr; b_derr = n_derr;
      b_mreq  = n_mreq;  b_dboth = n_dboth; b_done = done_n;
   endtask

   initial begin
      // Reset state.
      reset = 1'b1;
      cycle();
      cycle();
      check("rst_m_addr",  m_addr,  32'h0);
      check("rst_m_wdata", m_wdata, 32'h0);
      check("rst_rdata",   rdata,   32'h0);
      check("rst_m_we",    m_we,    32'h0);
      reset = 1'b0;
      cycle();

      // Core read, ack three cycles after m_req rises.
      ack_lat = 3; ack_data = 32'hDEADBEEF;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100; c_wdata = 32'h0;
      cycle();
      check("t1_grant_addr", m_addr, 32'h100);
      repeat (3) cycle();
      check("t1_not_yet_done", c_done, 32'h0);
      cycle();
      check("t1_c_done", c_done, 32'h1);
      check("t1_rdata",  rdata,  32'hDEADBEEF);
      check("t1_c_err",  c_err,  32'h0);
      cycle();
      check("t1_done_pulse", c_done, 32'h0);

      // Simultaneous requests after reset: core first, debug on the next edge.
      reset = 1'b1; cycle(); reset = 1'b0;
      ack_lat = 0;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      cycle();
      check("t2_core_first", m_addr, 32'h200);
      ack_data = 32'hC0C0C0C0;
      cycle();
      check("t2_c_done", c_done, 32'h1);
      cycle();
      check("t2_d_granted", m_addr, 32'h300);
      check("t2_d_m_req",   m_req,  32'h1);
      ack_data = 32'hD00DF00D;
      cycle();
      check("t2_d_done",  d_done, 32'h1);
      check("t2_d_rdata", rdata,  32'hD00DF00D);
      cycle();

      // Both requests held continuously: grants alternate.
      snap(); done_seq = 32'h0;
      hold_reqs = 1; ack_lat = 1; ack_data = 32'h5A5A5A5A;
      c_req = 1'b1; c_addr = 32'h1000; d_req = 1'b1; d_addr = 32'h2000;
      repeat (12) cycle();
      c_req = 1'b0; d_req = 1'b0; hold_reqs = 0;
      repeat (4) cycle();
      check("t3_done_count", done_n - b_done,   4);
      check("t3_order_cdcd", done_seq[15:0],   16'hCDCD);
      check("t3_no_overlap", n_overlap,         0);

      // Debug write that never gets an ack: timeout after TIMEOUT cycles.
      snap();
      ack_lat = 255;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
      repeat (20) cycle();
      check("t4_m_req_cycles", n_mreq - b_mreq,   TIMEOUT);
      check("t4_d_done",       n_ddone - b_ddone, 1);
      check("t4_d_err",        n_derr - b_derr,   1);
      check("t4_done_err_tog", n_dboth - b_dboth, 1);
      check("t4_rdata_kept",   rdata,             32'h5A5A5A5A);

      // Ack on the last permitted cycle: ack wins over the timeout.
      snap();
      ack_lat = TIMEOUT - 1; ack_data = 32'hA5A50F0F;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h500;
      repeat (20) cycle();
      check("t5_c_done",       n_cdone - b_cdone, 1);
      check("t5_c_err",        n_cerr - b_cerr,   0);
      check("t5_rdata",        rdata,             32'hA5A50F0F);
      check("t5_m_req_cycles", n_mreq - b_mreq,   TIMEOUT);

      // Reset two cycles into a core grant aborts it silently.
      snap();
      ack_lat = 255;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h600;
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      check("t6_m_req_dropped", m_req, 32'h0);
      reset = 1'b0;
      repeat (20) cycle();
      check("t6_no_done", n_cdone - b_cdone, 0);
      ack_lat = 1; ack_data = 32'h77777777;
      c_req = 1'b1; c_we = 1'b0; c_addr = 32'h700;
      repeat (4) cycle();
      check("t6_regrant_done", n_cdone - b_cdone, 1);
      check("t6_regrant_data", rdata,             32'h77777777);

      // Spurious ack while idle.
      snap();
      idle_ack = 1;
      repeat (5) cycle();
      idle_ack = 0;
      check("t7_no_done",  (n_cdone - b_cdone) + (n_ddone - b_ddone), 0);
      check("t7_no_m_req", n_mreq - b_mreq, 0);
      check("t7_rdata",    rdata,           32'h77777777);

      // Randomised traffic against the model.
      rand_mode = 1; rand_lat = 1;
      for (int i = 0; i < 1500; i++) begin
         if (!c_req && $urandom_range(0, 2) == 0) begin
            c_req = 1'b1; c_we = 1'($urandom_range(0, 1));
            c_addr = $urandom(); c_wdata = $urandom();
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom(); d_wdata = $urandom();
         end
         idle_ack = ($urandom_range(0, 7) == 0);
         ack_data = $urandom();
         cycle();
      end
      c_req = 1'b0; d_req = 1'b0; idle_ack = 0;
      repeat (TIMEOUT + 4) cycle();
      check("rand_no_overlap", n_overlap, 0);
      check("rand_idle_at_end", m_req,    32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no end of run, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
